// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART bootloader: UART register map, readdata
// field positions, FSM state and packet phase encodings.
package uart_loader_pkg;

  // UART slave register offsets
  localparam logic [2:0] UART_REG_DATA  = 3'h0;
  localparam logic [2:0] UART_REG_SPACE = 3'h4;

  // Bit positions inside i_uart_readdata
  localparam int RX_VALID_BIT = 15;
  localparam int FIELD_LSB    = 16;
  localparam int FIELD_MSB    = 23;

  // Protocol byte defaults
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_POLL,
    S_RX_WAIT,
    S_PARSE,
    S_MEM_WR,
    S_TX_POLL,
    S_TX_WAIT,
    S_TX_WR
  } state_e;

  typedef enum logic [2:0] {
    PH_HDR,
    PH_ADDR,
    PH_LEN,
    PH_DATA,
    PH_CSUM
  } phase_e;

  // Extract the 8-bit count field (rx used / tx space) from a UART read
  function automatic logic [7:0] uart_count_field(input logic [31:0] rd);
    return rd[FIELD_MSB:FIELD_LSB];
  endfunction

endpackage

// File: rtl/uart_loader_timer.sv
// Inter-byte timeout: down-counter reloaded on clear, expires at zero.
module uart_loader_timer #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: reload on clear, otherwise count down and stick at zero
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = LOAD;
    end else if (i_enable && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= LOAD;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == '0);

endmodule

// File: rtl/uart_loader.sv
// Serial bootloader: polls the UART, parses SYNC|ADDR|LEN|payload|CSUM
// packets, writes payload to memory as little-endian words, answers ACK/NAK.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for i_enable
// S_RX_POLL | issue read of UART data reg (or abort on timeout / go idle)
// S_RX_WAIT | wait read ack; valid byte -> S_PARSE, else repoll
// S_PARSE   | consume byte according to packet phase
// S_MEM_WR  | memory write held until i_mem_acknowledge
// S_TX_POLL | issue read of UART tx-space reg
// S_TX_WAIT | wait ack; space>0 -> start ACK/NAK write, else repoll
// S_TX_WR   | wait write ack, pulse o_done/o_error
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE       = DEF_NAK_BYTE
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_enable,
  output logic [2:0]  o_uart_address,
  output logic        o_uart_read,
  output logic        o_uart_write,
  output logic [31:0] o_uart_writedata,
  input  logic [31:0] i_uart_readdata,
  input  logic        i_uart_acknowledge,
  output logic [31:0] o_mem_address,
  output logic        o_mem_write,
  output logic [31:0] o_mem_writedata,
  output logic [3:0]  o_mem_byteenable,
  input  logic        i_mem_acknowledge,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  state_e      state_q;
  phase_e      phase_q;
  logic [1:0]  field_cnt_q;
  logic [7:0]  len_lo_q;
  logic [15:0] remaining_q;
  logic [1:0]  lane_q;
  logic [7:0]  csum_q;
  logic [7:0]  rx_byte_q;
  logic        resp_ok_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [2:0]  uart_addr_q;
  logic        uart_read_q;
  logic        uart_write_q;
  logic [31:0] uart_wdata_q;
  logic [31:0] mem_addr_q;
  logic        mem_write_q;
  logic [31:0] word_q;
  logic [3:0]  be_q;

  logic        rx_valid;
  logic        rx_taken;
  logic        tmr_clear;
  logic        tmr_enable;
  logic        tmr_expired;
  logic [15:0] len_full;
  logic        last_byte;
  logic        unused_readdata;

  assign rx_valid  = i_uart_readdata[RX_VALID_BIT];
  assign rx_taken  = (state_q == S_RX_WAIT) && i_uart_acknowledge && rx_valid;
  assign len_full  = {rx_byte_q, len_lo_q};
  assign last_byte = (remaining_q == 16'd1);

  // Timeout only runs inside a packet while waiting on the receive side;
  // memory and response phases are never aborted.
  assign tmr_clear  = !busy_q || rx_taken;
  assign tmr_enable = busy_q &&
                      ((state_q == S_RX_POLL) || (state_q == S_RX_WAIT) || (state_q == S_PARSE));

  assign unused_readdata = ^{i_uart_readdata[31:24], i_uart_readdata[14:8]};

  uart_loader_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (tmr_clear),
    .i_enable  (tmr_enable),
    .o_expired (tmr_expired)
  );

  // Loader FSM with all bus strobes and status outputs registered
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_HDR;
      field_cnt_q  <= 2'd0;
      len_lo_q     <= 8'h00;
      remaining_q  <= 16'h0000;
      lane_q       <= 2'd0;
      csum_q       <= 8'h00;
      rx_byte_q    <= 8'h00;
      resp_ok_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      uart_addr_q  <= UART_REG_DATA;
      uart_read_q  <= 1'b0;
      uart_write_q <= 1'b0;
      uart_wdata_q <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_write_q  <= 1'b0;
      word_q       <= 32'h0;
      be_q         <= 4'h0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_enable) state_q <= S_RX_POLL;
        end

        S_RX_POLL: begin
          if (busy_q && tmr_expired) begin
            resp_ok_q <= 1'b0;
            phase_q   <= PH_HDR;
            state_q   <= S_TX_POLL;
          end else if (!busy_q && !i_enable) begin
            // Between packets only: a packet in flight always completes.
            state_q <= S_IDLE;
          end else begin
            uart_addr_q <= UART_REG_DATA;
            uart_read_q <= 1'b1;
            state_q     <= S_RX_WAIT;
          end
        end

        S_RX_WAIT: begin
          if (i_uart_acknowledge) begin
            uart_read_q <= 1'b0;
            if (rx_valid) begin
              rx_byte_q <= i_uart_readdata[7:0];
              state_q   <= S_PARSE;
            end else begin
              state_q <= S_RX_POLL;
            end
          end
        end

        S_PARSE: begin
          state_q <= S_RX_POLL;
          case (phase_q)
            PH_HDR: begin
              if (rx_byte_q == SYNC_BYTE) begin
                phase_q     <= PH_ADDR;
                field_cnt_q <= 2'd0;
                csum_q      <= 8'h00;
                busy_q      <= 1'b1;
                word_q      <= 32'h0;
                be_q        <= 4'h0;
                lane_q      <= 2'd0;
              end
            end

            PH_ADDR: begin
              mem_addr_q[{field_cnt_q, 3'b000} +: 8] <= rx_byte_q;
              csum_q      <= csum_q ^ rx_byte_q;
              field_cnt_q <= field_cnt_q + 2'd1;
              if (field_cnt_q == 2'd3) begin
                field_cnt_q <= 2'd0;
                phase_q     <= PH_LEN;
              end
            end

            PH_LEN: begin
              csum_q <= csum_q ^ rx_byte_q;
              if (field_cnt_q == 2'd0) begin
                len_lo_q    <= rx_byte_q;
                field_cnt_q <= 2'd1;
              end else begin
                field_cnt_q     <= 2'd0;
                remaining_q     <= len_full;
                // Payload always starts in lane 0 of a word-aligned address.
                mem_addr_q[1:0] <= 2'b00;
                phase_q         <= (len_full == 16'h0000) ? PH_CSUM : PH_DATA;
              end
            end

            PH_DATA: begin
              csum_q                          <= csum_q ^ rx_byte_q;
              word_q[{lane_q, 3'b000} +: 8]   <= rx_byte_q;
              be_q[lane_q]                    <= 1'b1;
              lane_q                          <= lane_q + 2'd1;
              if (remaining_q != 16'h0000) remaining_q <= remaining_q - 16'd1;
              if ((lane_q == 2'd3) || last_byte) begin
                mem_write_q <= 1'b1;
                state_q     <= S_MEM_WR;
                if (last_byte) phase_q <= PH_CSUM;
              end
            end

            PH_CSUM: begin
              resp_ok_q <= (csum_q == rx_byte_q);
              phase_q   <= PH_HDR;
              state_q   <= S_TX_POLL;
            end

            default: phase_q <= PH_HDR;
          endcase
        end

        S_MEM_WR: begin
          if (i_mem_acknowledge) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= mem_addr_q + 32'd4;
            word_q      <= 32'h0;
            be_q        <= 4'h0;
            lane_q      <= 2'd0;
            state_q     <= S_RX_POLL;
          end
        end

        S_TX_POLL: begin
          uart_addr_q <= UART_REG_SPACE;
          uart_read_q <= 1'b1;
          state_q     <= S_TX_WAIT;
        end

        S_TX_WAIT: begin
          if (i_uart_acknowledge) begin
            uart_read_q <= 1'b0;
            if (uart_count_field(i_uart_readdata) != 8'h00) begin
              uart_addr_q  <= UART_REG_DATA;
              uart_write_q <= 1'b1;
              uart_wdata_q <= {24'h0, (resp_ok_q ? ACK_BYTE : NAK_BYTE)};
              state_q      <= S_TX_WR;
            end else begin
              state_q <= S_TX_POLL;
            end
          end
        end

        S_TX_WR: begin
          if (i_uart_acknowledge) begin
            uart_write_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= resp_ok_q;
            error_q      <= !resp_ok_q;
            state_q      <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_uart_address   = uart_addr_q;
  assign o_uart_read      = uart_read_q;
  assign o_uart_write     = uart_write_q;
  assign o_uart_writedata = uart_wdata_q;
  assign o_mem_address    = mem_addr_q;
  assign o_mem_write      = mem_write_q;
  assign o_mem_writedata  = word_q;
  assign o_mem_byteenable = be_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_error          = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: UART and memory slave models, packet-level
// reference model with expectation queues, directed and random packets.
module tb_uart_loader;

  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  uart_address;
  logic        uart_read, uart_write;
  logic [31:0] uart_writedata;
  logic [31:0] uart_rd = 32'h0;
  logic        uart_ack = 1'b0;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        busy, done, error;

  always #5 clk = ~clk;

  uart_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_enable           (en),
    .o_uart_address     (uart_address),
    .o_uart_read        (uart_read),
    .o_uart_write       (uart_write),
    .o_uart_writedata   (uart_writedata),
    .i_uart_readdata    (uart_rd),
    .i_uart_acknowledge (uart_ack),
    .o_mem_address      (mem_address),
    .o_mem_write        (mem_write),
    .o_mem_writedata    (mem_writedata),
    .o_mem_byteenable   (mem_be),
    .i_mem_acknowledge  (mem_ack),
    .o_busy             (busy),
    .o_done             (done),
    .o_error            (error)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  logic [7:0] rx_q[$];
  wr_t        exp_mem[$];
  logic [7:0] exp_tx[$];
  bit         exp_resp[$];

  int n_cmp = 0;
  int n_bad = 0;
  int resp_cnt = 0;
  int rd_acks = 0;
  int tx_stall = 0, tx_zero_polls = 0, tx_writes = 0;
  int mem_force = -1, mem_wait = 0, mem_hold = 0, last_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h want nothing", name, act);
  endtask

  // UART slave: ack arrives one cycle after the strobe is first seen
  int         uart_age = 0;
  bit         acked_read = 0, acked_write = 0;
  logic [7:0] rxb;
  always @(negedge clk) begin
    if (!rst_n) begin
      uart_ack = 1'b0;
      uart_age = 0;
    end else if (uart_ack) begin
      uart_ack = 1'b0;
      uart_age = 0;
      if (acked_read)  chk("uart_read_drop", 32'(uart_read), 32'd0);
      if (acked_write) chk("uart_write_drop", 32'(uart_write), 32'd0);
    end else if (uart_read || uart_write) begin
      if (uart_age < 1) begin
        uart_age++;
      end else begin
        uart_ack    = 1'b1;
        acked_read  = uart_read;
        acked_write = uart_write;
        if (uart_read && uart_write) flag("uart_read_and_write", 32'd1);
        if (uart_write) begin
          tx_writes++;
          chk("uart_wr_addr", 32'(uart_address), 32'd0);
          if (exp_tx.size() == 0) flag("uart_wr_unexpected", uart_writedata);
          else chk("uart_wr_data", uart_writedata, {24'h0, exp_tx.pop_front()});
          uart_rd = 32'h0;
        end else if (uart_address == 3'h4) begin
          if (tx_stall > 0) begin
            tx_stall--;
            tx_zero_polls++;
            uart_rd = 32'h0;
          end else begin
            uart_rd = {8'h0, 8'($urandom_range(1, 64)), 16'h0};
          end
        end else begin
          rd_acks++;
          if (rx_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            rxb = rx_q.pop_front();
            uart_rd = {8'h0, 8'(rx_q.size() + 1), 1'b1, 7'h0, rxb};
          end else begin
            uart_rd = {16'h0, 1'b0, 7'h0, 8'($urandom_range(0, 255))};
          end
        end
      end
    end
  end

  // Memory slave: random or forced wait; checks write is held and stable
  bit         mem_pend = 0;
  logic [31:0] held_d, held_a;
  wr_t        ew;
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack  = 1'b0;
      mem_pend = 0;
    end else if (mem_ack) begin
      mem_ack  = 1'b0;
      mem_pend = 0;
      chk("mem_write_drop", 32'(mem_write), 32'd0);
    end else if (mem_write) begin
      if (mem_pend) begin
        mem_hold++;
        chk("mem_held_data", mem_writedata, held_d);
        chk("mem_held_addr", mem_address, held_a);
      end else begin
        mem_pend = 1;
        mem_hold = 1;
        held_d   = mem_writedata;
        held_a   = mem_address;
        mem_wait = (mem_force >= 0) ? mem_force : $urandom_range(0, 4);
      end
      if (mem_wait == 0) begin
        mem_ack   = 1'b1;
        last_hold = mem_hold;
        if (exp_mem.size() == 0) begin
          flag("mem_wr_unexpected", mem_address);
        end else begin
          ew = exp_mem.pop_front();
          chk("mem_wr_addr", mem_address, ew.a);
          chk("mem_wr_data", mem_writedata, ew.d);
          chk("mem_wr_be", 32'(mem_be), 32'(ew.be));
        end
      end else begin
        mem_wait--;
      end
    end else if (mem_pend) begin
      flag("mem_write_dropped_early", mem_address);
      mem_pend = 0;
    end
  end

  // Response pulse monitor
  bit r_exp;
  always @(negedge clk) begin
    if (rst_n && (done || error)) begin
      resp_cnt++;
      if (exp_resp.size() == 0) begin
        flag("resp_unexpected", {30'h0, done, error});
      end else begin
        r_exp = exp_resp.pop_front();
        chk("done_pulse", 32'(done), 32'(r_exp));
        chk("error_pulse", 32'(error), 32'(!r_exp));
      end
      chk("busy_after_resp", 32'(busy), 32'd0);
    end
  end

  // Packet model: queue host bytes and the writes/response they must cause
  task automatic model_packet(input logic [31:0] addr, input int len, input bit corrupt,
                              input int n_garbage);
    logic [7:0]  pl[$];
    logic [7:0]  cs;
    logic [7:0]  bb;
    logic [15:0] lenv;
    wr_t         w;
    for (int g = 0; g < n_garbage; g++) begin
      bb = 8'($urandom_range(0, 255));
      if (bb == 8'hA5) bb = 8'h5A;
      rx_q.push_back(bb);
    end
    rx_q.push_back(8'hA5);
    cs = 8'h00;
    for (int i = 0; i < 4; i++) begin
      bb = 8'(addr >> (8 * i));
      rx_q.push_back(bb);
      cs ^= bb;
    end
    lenv = 16'(len);
    rx_q.push_back(lenv[7:0]);
    rx_q.push_back(lenv[15:8]);
    cs = cs ^ lenv[7:0] ^ lenv[15:8];
    for (int i = 0; i < len; i++) begin
      bb = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      pl.push_back(bb);
      rx_q.push_back(bb);
      cs ^= bb;
    end
    rx_q.push_back(corrupt ? ~cs : cs);
    for (int wi = 0; wi * 4 < len; wi++) begin
      w.a  = (addr & 32'hFFFF_FFFC) + 32'(4 * wi);
      w.d  = 32'h0;
      w.be = 4'h0;
      for (int l = 0; l < 4; l++) begin
        if (wi * 4 + l < len) begin
          w.d  = w.d | (32'(pl[wi * 4 + l]) << (8 * l));
          w.be = w.be | 4'(1 << l);
        end
      end
      exp_mem.push_back(w);
    end
    exp_tx.push_back(corrupt ? 8'h15 : 8'h06);
    exp_resp.push_back(!corrupt);
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n = 0;
    while (resp_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (resp_cnt < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_wait_expired: got %0d responses want %0d", resp_cnt, target);
      exp_mem.delete(); exp_tx.delete(); exp_resp.delete(); rx_q.delete();
    end
    repeat (3) @(negedge clk);
    chk("mem_writes_all_seen", 32'(exp_mem.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_uart_address", 32'(uart_address), 32'd0);
    chk("rst_uart_read", 32'(uart_read), 32'd0);
    chk("rst_uart_write", 32'(uart_write), 32'd0);
    chk("rst_uart_writedata", uart_writedata, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1[12] = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00,
                         8'h11, 8'h22, 8'h33, 8'h44, 8'h41};
  logic [7:0] t2[13] = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h05, 8'h00,
                         8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h05};
  int target, n, r0, z0, w0, rd0;

  initial begin
    repeat (4) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    en    = 1'b1;

    // LEN=4 literal packet
    foreach (t1[i]) rx_q.push_back(t1[i]);
    exp_mem.push_back('{32'h0000_0100, 32'h4433_2211, 4'hF});
    exp_tx.push_back(8'h06);
    exp_resp.push_back(1'b1);
    wait_resp(1, 3000);

    // LEN=5 literal packet: full word then partial word
    foreach (t2[i]) rx_q.push_back(t2[i]);
    exp_mem.push_back('{32'h0000_0100, 32'h0403_0201, 4'hF});
    exp_mem.push_back('{32'h0000_0104, 32'h0000_0005, 4'h1});
    exp_tx.push_back(8'h06);
    exp_resp.push_back(1'b1);
    wait_resp(2, 3000);

    // Corrupted checksum: writes still happen, NAK
    foreach (t1[i]) rx_q.push_back((i == 11) ? 8'h40 : t1[i]);
    exp_mem.push_back('{32'h0000_0100, 32'h4433_2211, 4'hF});
    exp_tx.push_back(8'h15);
    exp_resp.push_back(1'b0);
    wait_resp(3, 3000);

    // SYNC then silence: timeout NAK, then a good packet
    rx_q.push_back(8'hA5);
    exp_tx.push_back(8'h15);
    exp_resp.push_back(1'b0);
    wait_resp(4, 3 * TO + 500);
    chk("idle_after_timeout", 32'(busy), 32'd0);
    model_packet(32'h0000_0040, 3, 0, 0);
    wait_resp(5, 3000);

    // Garbage before SYNC, memory ack delayed 7 cycles
    rx_q.push_back(8'h00); rx_q.push_back(8'hFF); rx_q.push_back(8'h13);
    mem_force = 7;
    model_packet(32'h0000_0200, 4, 0, 0);
    wait_resp(6, 3000);
    chk("mem_hold_cycles", 32'(last_hold), 32'd8);
    mem_force = -1;

    // Zero length and unaligned start address
    model_packet(32'h1234_5677, 0, 0, 0);
    wait_resp(7, 3000);
    model_packet(32'h0000_1003, 6, 0, 1);
    wait_resp(8, 3000);

    // TX space zero for 20 polls
    tx_stall = 20;
    z0 = tx_zero_polls;
    w0 = tx_writes;
    model_packet(32'h0000_0300, 2, 0, 0);
    wait_resp(9, 5000);
    chk("tx_zero_polls", 32'(tx_zero_polls - z0), 32'd20);
    chk("tx_single_write", 32'(tx_writes - w0), 32'd1);

    // Enable dropped mid-packet: packet completes, then loader idles
    model_packet(32'h0000_0400, 6, 0, 0);
    n = 0;
    while (!busy && n < 2000) begin @(negedge clk); n++; end
    chk("busy_seen", 32'(busy), 32'd1);
    en = 1'b0;
    wait_resp(10, 5000);
    rd0 = rd_acks;
    model_packet(32'h0000_0500, 3, 0, 0);
    repeat (100) @(negedge clk);
    chk("reads_while_disabled", 32'(rd_acks - rd0), 32'd0);
    en = 1'b1;
    wait_resp(11, 3000);

    // Random packets
    target = 11;
    for (int k = 0; k < 14; k++) begin
      model_packet(32'($urandom), $urandom_range(0, 11), ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 2));
      target++;
      wait_resp(target, 5000);
    end

    // Reset mid-payload: abort silently
    model_packet(32'h0000_0800, 8, 0, 0);
    while (rx_q.size() > 10) void'(rx_q.pop_back());
    n = 0;
    while (rx_q.size() > 0 && n < 2000) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk("busy_mid_payload", 32'(busy), 32'd1);
    r0 = resp_cnt;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    exp_mem.delete(); exp_tx.delete(); exp_resp.delete(); rx_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_resp_after_reset", 32'(resp_cnt), 32'(r0));
    model_packet(32'h0000_0900, 5, 0, 0);
    wait_resp(r0 + 1, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
